// File: rtl/fetch_queue.sv
// fetch_queue: single-outstanding instruction fetch feeding a DEPTH-entry decode queue,
// with redirect flush of buffered/in-flight fetches and optional control/memory serialisation.
module fetch_queue #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] PCINIT    = ADDR_W'(64'h8000_0000),
  parameter int                DEPTH     = 4,
  parameter int                TAG_W     = 64,
  parameter bit                SERIALIZE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ireq_valid,
  output logic [ADDR_W-1:0] ireq_addr,
  input  logic              iresp_addr_ok,
  input  logic              iresp_data_ok,
  input  logic [31:0]       iresp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic [TAG_W-1:0]  commit_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [TAG_W-1:0]  out_tag,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              idle
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d, ireq_addr_q, ireq_addr_d;
  logic              ireq_valid_q, ireq_valid_d, inflight_q, inflight_d;
  logic              drop_q, drop_d, halted_q, halted_d;
  logic [TAG_W-1:0]  tag_q, tag_d, wait_tag_q, wait_tag_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic [31:0]       inst_q [DEPTH];
  logic [31:0]       inst_d [DEPTH];
  logic [ADDR_W-1:0] pc_q [DEPTH];
  logic [ADDR_W-1:0] pc_d [DEPTH];
  logic [TAG_W-1:0]  etag_q [DEPTH];
  logic [TAG_W-1:0]  etag_d [DEPTH];
  logic              done, enq, deq, issue, serial;
  assign out_valid  = count_q != '0;
  assign out_inst   = out_valid ? inst_q[head_q] : '0;
  assign out_pc     = out_valid ? pc_q[head_q] : '0;
  assign out_tag    = out_valid ? etag_q[head_q] : '0;
  assign ireq_valid = ireq_valid_q;
  assign ireq_addr  = ireq_addr_q;
  assign fetch_pc   = next_pc_q;
  assign idle       = !inflight_q;
  always_comb begin
    done   = inflight_q & iresp_addr_ok & iresp_data_ok;
    enq    = done & !drop_q & !redirect_valid;
    deq    = out_valid & out_ready;
    // count < DEPTH is just the clear MSB since DEPTH is a power of two
    issue  = !inflight_q & !halted_q & !redirect_valid & !count_q[PW];
    serial = SERIALIZE && (iresp_data[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0100011});
    next_pc_d    = redirect_valid ? redirect_addr : issue ? next_pc_q + ADDR_W'(4) : next_pc_q;
    ireq_valid_d = issue | (ireq_valid_q & !done);
    ireq_addr_d  = issue ? next_pc_q : ireq_addr_q;
    inflight_d   = issue | (inflight_q & !done);
    drop_d       = (redirect_valid | drop_q) & inflight_q & !done;
    tag_d        = enq ? tag_q + TAG_W'(1) : tag_q;
    halted_d     = redirect_valid ? 1'b0 : (enq & serial) ? 1'b1 : halted_q & (commit_tag != wait_tag_q);
    wait_tag_d   = (enq & serial) ? tag_q + TAG_W'(1) : wait_tag_q;
    head_d       = redirect_valid ? '0 : head_q + PW'(deq);
    tail_d       = redirect_valid ? '0 : tail_q + PW'(enq);
    count_d      = redirect_valid ? '0 : count_q + CW'(enq) - CW'(deq);
    inst_d = inst_q;
    pc_d   = pc_q;
    etag_d = etag_q;
    if (enq) begin
      inst_d[tail_q] = iresp_data;
      pc_d[tail_q]   = ireq_addr_q;
      etag_d[tail_q] = tag_q + TAG_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      next_pc_q    <= PCINIT;
      ireq_valid_q <= 1'b0;
      ireq_addr_q  <= '0;
      inflight_q   <= 1'b0;
      drop_q       <= 1'b0;
      halted_q     <= 1'b0;
      tag_q        <= '0;
      wait_tag_q   <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else begin
      next_pc_q    <= next_pc_d;
      ireq_valid_q <= ireq_valid_d;
      ireq_addr_q  <= ireq_addr_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      halted_q     <= halted_d;
      tag_q        <= tag_d;
      wait_tag_q   <= wait_tag_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
    end
    inst_q <= inst_d;
    pc_q   <= pc_d;
    etag_q <= etag_d;
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: table vectors, directed corner sequences and random traffic against a queue-based model.
module tb_fetch_queue;
  localparam int D = 4;
  localparam logic [63:0] PCI = 64'h8000_0000;
  logic clk = 0, rst = 0;
  logic aok = 0, dok = 0, rdy = 0, redir = 0;
  logic [31:0] idata = 0;
  logic [63:0] raddr = 0, commit = 0;
  logic ireq_valid, out_valid, idle;
  logic [63:0] ireq_addr, out_pc, out_tag, fetch_pc;
  logic [31:0] out_inst;
  always #5 clk = ~clk;

  fetch_queue #(.ADDR_W(64), .PCINIT(PCI), .DEPTH(D), .TAG_W(64), .SERIALIZE(1'b1)) dut (
    .clk(clk), .rst(rst), .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(aok), .iresp_data_ok(dok), .iresp_data(idata),
    .redirect_valid(redir), .redirect_addr(raddr), .commit_tag(commit),
    .out_valid(out_valid), .out_ready(rdy), .out_inst(out_inst), .out_pc(out_pc),
    .out_tag(out_tag), .fetch_pc(fetch_pc), .idle(idle));

  typedef struct {logic [31:0] inst; logic [63:0] pc; logic [63:0] tag;} ent_t;
  ent_t mq[$];
  logic [63:0] m_pc, m_addr, m_tag, m_wait;
  bit m_busy, m_drop, m_halt;
  int vecs = 0, errs = 0;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask

  function automatic bit is_ser(logic [31:0] w);
    return w[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0100011};
  endfunction

  // Reference: one outstanding bus fetch, a FIFO of fetched words, plus halt/drop flags.
  task automatic model_step();
    bit done, iss;
    int sz;
    if (!rst) begin
      m_pc = PCI; m_addr = 0; m_tag = 0; m_wait = 0;
      m_busy = 0; m_drop = 0; m_halt = 0;
      mq.delete();
    end else begin
      done = m_busy && aok && dok;
      sz = mq.size();
      iss = !m_busy && !m_halt && !redir && sz < D;
      if (m_halt && commit == m_wait) m_halt = 0;
      if (sz > 0 && rdy) void'(mq.pop_front());
      if (done) begin
        m_busy = 0;
        if (m_drop || redir) m_drop = 0;
        else begin
          m_tag++;
          mq.push_back('{idata, m_addr, m_tag});
          if (is_ser(idata)) begin m_halt = 1; m_wait = m_tag; end
        end
      end
      if (redir) begin
        if (m_busy) m_drop = 1;
        mq.delete();
        m_pc = raddr;
        m_halt = 0;
      end
      if (iss) begin m_busy = 1; m_addr = m_pc; m_pc += 4; end
    end
  endtask

  task automatic cyc();
    ent_t h;
    model_step();
    @(posedge clk);
    #1;
    h = mq.size() > 0 ? mq[0] : '{32'h0, 64'h0, 64'h0};
    chk("ireq_valid", ireq_valid, m_busy);
    chk("ireq_addr", ireq_addr, m_addr);
    chk("out_valid", out_valid, mq.size() > 0);
    chk("out_inst", out_inst, h.inst);
    chk("out_pc", out_pc, h.pc);
    chk("out_tag", out_tag, h.tag);
    chk("fetch_pc", fetch_pc, m_pc);
    chk("idle", idle, !m_busy);
  endtask

  task automatic do_reset();
    rst = 0; redir = 0; commit = 0; aok = 0; dok = 0; rdy = 0; idata = 32'h13;
    cyc(); cyc();
    chk("rst_iv", ireq_valid, 0);
    chk("rst_addr", ireq_addr, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_fpc", fetch_pc, PCI);
    chk("rst_idle", idle, 1);
    rst = 1;
  endtask

  typedef struct {
    logic aok, dok, rdy; logic [31:0] data;
    logic e_iv; logic [63:0] e_addr; logic e_ov; logic [63:0] e_pc, e_tag, e_fpc;
  } vec_t;
  vec_t tbl[6];
  logic [31:0] words[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    tbl[0] = '{1, 1, 1, 32'h13, 1, 64'h8000_0000, 0, 64'h0,          64'h0, 64'h8000_0004};
    tbl[1] = '{1, 1, 1, 32'h13, 0, 64'h8000_0000, 1, 64'h8000_0000, 64'h1, 64'h8000_0004};
    tbl[2] = '{1, 1, 1, 32'h13, 1, 64'h8000_0004, 0, 64'h0,          64'h0, 64'h8000_0008};
    tbl[3] = '{1, 1, 1, 32'h13, 0, 64'h8000_0004, 1, 64'h8000_0004, 64'h2, 64'h8000_0008};
    tbl[4] = '{1, 1, 1, 32'h13, 1, 64'h8000_0008, 0, 64'h0,          64'h0, 64'h8000_000C};
    tbl[5] = '{1, 1, 1, 32'h13, 0, 64'h8000_0008, 1, 64'h8000_0008, 64'h3, 64'h8000_000C};
    words = '{32'h13, 32'h63, 32'h6f, 32'h67, 32'h03, 32'h23, 32'h0000_0033};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      aok = tbl[i].aok; dok = tbl[i].dok; rdy = tbl[i].rdy; idata = tbl[i].data;
      cyc();
      chk("tbl_iv", ireq_valid, tbl[i].e_iv);
      chk("tbl_addr", ireq_addr, tbl[i].e_addr);
      chk("tbl_ov", out_valid, tbl[i].e_ov);
      chk("tbl_pc", out_pc, tbl[i].e_pc);
      chk("tbl_tag", out_tag, tbl[i].e_tag);
      chk("tbl_fpc", fetch_pc, tbl[i].e_fpc);
    end
    // queue fills to DEPTH with decode stalled, then resumes
    do_reset(); rdy = 0; aok = 1; dok = 1;
    repeat (12) cyc();
    chk("fill_no_req", ireq_valid, 0);
    chk("fill_fpc", fetch_pc, 64'h8000_0010);
    chk("fill_head", out_tag, 1);
    rdy = 1; cyc();
    chk("fill_still_no_req", ireq_valid, 0);
    cyc();
    chk("resume_iv", ireq_valid, 1);
    chk("resume_addr", ireq_addr, 64'h8000_0010);
    // redirect with 3 queued and one in flight
    do_reset(); rdy = 0; aok = 1; dok = 1; g = 0;
    while (!(mq.size() == 3 && m_busy) && g < 20) begin cyc(); g++; end
    aok = 0; redir = 1; raddr = 64'h8000_0100; cyc(); redir = 0;
    chk("redir_ov", out_valid, 0);
    chk("redir_inflight", idle, 0);
    aok = 1; cyc();
    chk("drop_idle", idle, 1);
    chk("drop_ov", out_valid, 0);
    cyc();
    chk("redir_req", ireq_addr, 64'h8000_0100);
    chk("redir_iv", ireq_valid, 1);
    cyc();
    chk("redir_pc", out_pc, 64'h8000_0100);
    chk("redir_tag", out_tag, 4);
    // serialising branch at tag 5 halts fetch until committed
    do_reset(); rdy = 1; aok = 1; dok = 1; g = 0;
    while (m_tag < 4 && g < 50) begin cyc(); g++; end
    idata = 32'h0000_0063;
    while (m_tag < 5 && g < 60) begin cyc(); g++; end
    idata = 32'h13;
    chk("ser_tag", out_tag, 5);
    chk("ser_inst", out_inst, 32'h63);
    chk("ser_pc", out_pc, 64'h8000_0010);
    repeat (5) begin cyc(); chk("ser_halt", ireq_valid, 0); end
    commit = 5; cyc();
    chk("ser_release_edge", ireq_valid, 0);
    cyc();
    chk("ser_resume_iv", ireq_valid, 1);
    chk("ser_resume_addr", ireq_addr, 64'h8000_0014);
    commit = 0;
    // response and redirect in the same cycle
    do_reset(); aok = 1; dok = 1; rdy = 1; cyc();
    redir = 1; raddr = 64'h8000_0200; cyc(); redir = 0;
    chk("rr_ov", out_valid, 0);
    chk("rr_idle", idle, 1);
    cyc();
    chk("rr_iv", ireq_valid, 1);
    chk("rr_addr", ireq_addr, 64'h8000_0200);
    cyc();
    chk("rr_pc", out_pc, 64'h8000_0200);
    chk("rr_tag", out_tag, 1);
    // reset while a transaction is pending
    do_reset(); aok = 0; cyc(); cyc();
    chk("mid_busy", idle, 0);
    aok = 1; dok = 1; rst = 0; cyc();
    chk("mid_iv", ireq_valid, 0);
    chk("mid_addr", ireq_addr, 0);
    chk("mid_ov", out_valid, 0);
    chk("mid_fpc", fetch_pc, PCI);
    chk("mid_idle", idle, 1);
    rst = 1; cyc();
    chk("mid_first_req", ireq_addr, PCI);
    chk("mid_first_iv", ireq_valid, 1);
    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int k;
      rst = $urandom_range(0, 299) != 0;
      aok = $urandom_range(0, 2) != 0;
      dok = $urandom_range(0, 2) != 0;
      rdy = $urandom_range(0, 1) != 0;
      redir = $urandom_range(0, 15) == 0;
      raddr = {$urandom, $urandom} & ~64'h3;
      k = $urandom_range(0, 7);
      idata = k < 7 ? words[k] : $urandom;
      commit = (m_halt && $urandom_range(0, 3) == 0) ? m_wait : 64'($urandom_range(0, 7));
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
